password_attempt_controller: RTL and testbench

Supervisory controller that sequences password-entry attempts on the button-sequence detector. It gates debounced button pulses into the detector and issues a one-cycle restart between attempts. It also counts failed attempts, enforces an entry timeout, holds the unlock indication for a fixed time, and locks out input after `MAX_FAIL` consecutive failures. It sits between the button debounce FSMs and the sequence detector, and drives a status digit to the seven-segment decoder.

---
 rtl/password_pkg.sv | 20 ++
 rtl/cycle_timer.sv | 27 ++
 rtl/password_attempt_controller.sv | 137 +++++++++++++
 tb/tb_password_attempt_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/password_pkg.sv
// Shared constants for the password attempt controller: state encodings,
// status digit codes and the MAX_FAIL range check.
package password_pkg;

   localparam logic [2:0] ST_CLEAR   = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_ENTRY   = 3'd2;
   localparam logic [2:0] ST_GRANT   = 3'd3;
   localparam logic [2:0] ST_DENY    = 3'd4;
   localparam logic [2:0] ST_LOCKOUT = 3'd5;

   localparam logic [3:0] DIG_GRANT = 4'd9;
   localparam logic [3:0] DIG_LOCK  = 4'd8;

   // fail_cnt is 3 bits wide, so the lockout threshold must fit in 1..7.
   function automatic bit max_fail_ok(input int unsigned max_fail);
      return (max_fail >= 1) && (max_fail <= 7);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; shared by the entry timeout,
// unlock hold and lockout hold.
module cycle_timer #(
   parameter int unsigned CNT_W = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/password_attempt_controller.sv
// Sequences password attempts on the button-sequence detector: gates key
// pulses, restarts the detector, counts failures and enforces lockout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CLEAR   | one-cycle restart pulse to the detector
//   ARMED   | waiting for the first key pulse, no timeout
//   ENTRY   | code entry in progress, idle timeout running
//   GRANT   | access granted for UNLOCK_CYCLES
//   DENY    | one cycle after a failed attempt, decides on lockout
//   LOCKOUT | input blocked for LOCK_CYCLES after MAX_FAIL failures
module password_attempt_controller
   import password_pkg::*;
#(
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
   parameter int unsigned UNLOCK_CYCLES  = 300_000_000,
   parameter int unsigned LOCK_CYCLES    = 1_000_000_000,
   parameter int unsigned CNT_W          = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_pulse,
   input  logic       seq_ok,
   input  logic       seq_err,
   output logic       btn_en,
   output logic       fsm_clr,
   output logic       unlocked,
   output logic       locked,
   output logic [2:0] fail_cnt,
   output logic [3:0] status_digit
);

   generate
      if (!max_fail_ok(MAX_FAIL)) begin : g_max_fail_illegal
         $error("password_attempt_controller: MAX_FAIL must be in 1..7");
      end
   endgenerate

   localparam logic [2:0]       FAIL_MAX   = 3'(MAX_FAIL);
   localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_UNLOCK  = CNT_W'(UNLOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_LOCK    = CNT_W'(LOCK_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [2:0]       fail_q, fail_d, fail_inc;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val;

   assign fail_inc = (fail_q < FAIL_MAX) ? fail_q + 3'd1 : fail_q;

   always_comb begin
      state_d  = state_q;
      fail_d   = fail_q;
      tmr_load = 1'b0;
      tmr_val  = LD_TIMEOUT;
      case (state_q)
         ST_CLEAR: state_d = ST_ARMED;
         ST_ARMED: begin
            if (key_pulse) begin
               state_d  = ST_ENTRY;
               tmr_load = 1'b1;
            end
         end
         ST_ENTRY: begin
            // An error outranks a simultaneous success; a fresh key pulse
            // outranks an expiring timer.
            if (seq_err) begin
               state_d = ST_DENY;
               fail_d  = fail_inc;
            end else if (seq_ok) begin
               state_d  = ST_GRANT;
               fail_d   = '0;
               tmr_load = 1'b1;
               tmr_val  = LD_UNLOCK;
            end else if (key_pulse) begin
               tmr_load = 1'b1;
            end else if (tmr_zero) begin
               state_d = ST_DENY;
               fail_d  = fail_inc;
            end
         end
         ST_GRANT: begin
            if (tmr_zero) state_d = ST_CLEAR;
         end
         ST_DENY: begin
            if (fail_q == FAIL_MAX) begin
               state_d  = ST_LOCKOUT;
               tmr_load = 1'b1;
               tmr_val  = LD_LOCK;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_zero) begin
               state_d = ST_CLEAR;
               fail_d  = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_CLEAR;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
      end
   end

   cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   assign fsm_clr  = (state_q == ST_CLEAR);
   assign btn_en   = (state_q == ST_ARMED) || (state_q == ST_ENTRY);
   assign unlocked = (state_q == ST_GRANT);
   assign locked   = (state_q == ST_LOCKOUT);
   assign fail_cnt = fail_q;

   always_comb begin
      case (state_q)
         ST_GRANT:   status_digit = DIG_GRANT;
         ST_LOCKOUT: status_digit = DIG_LOCK;
         default:    status_digit = {1'b0, fail_q};
      endcase
   end

endmodule

// File: tb/tb_password_attempt_controller.sv
// Directed bench: each stimulus cycle queues the hand-computed outputs for
// that cycle; an independent monitor pops and compares on the falling edge.
module tb_password_attempt_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       key_pulse = 1'b0;
   logic       seq_ok = 1'b0;
   logic       seq_err = 1'b0;
   logic       btn_en, fsm_clr, unlocked, locked;
   logic [2:0] fail_cnt;
   logic [3:0] status_digit;

   int n_cmp = 0;
   int n_bad = 0;

   logic [10:0] exp_q[$];
   string       name_q[$];

   password_attempt_controller #(
      .MAX_FAIL       (3),
      .TIMEOUT_CYCLES (20),
      .UNLOCK_CYCLES  (10),
      .LOCK_CYCLES    (50),
      .CNT_W          (6)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_pulse    (key_pulse),
      .seq_ok       (seq_ok),
      .seq_err      (seq_err),
      .btn_en       (btn_en),
      .fsm_clr      (fsm_clr),
      .unlocked     (unlocked),
      .locked       (locked),
      .fail_cnt     (fail_cnt),
      .status_digit (status_digit)
   );

   always #5 clk = ~clk;

   // {fsm_clr, btn_en, unlocked, locked, fail_cnt, status_digit}
   function automatic logic [10:0] mk(input logic clr, input logic en, input logic unl,
                                      input logic lck, input logic [2:0] fc,
                                      input logic [3:0] dig);
      return {clr, en, unl, lck, fc, dig};
   endfunction
   function automatic logic [10:0] e_clr(input logic [2:0] fc);
      return mk(1'b1, 1'b0, 1'b0, 1'b0, fc, {1'b0, fc});
   endfunction
   function automatic logic [10:0] e_arm(input logic [2:0] fc);
      return mk(1'b0, 1'b1, 1'b0, 1'b0, fc, {1'b0, fc});
   endfunction
   function automatic logic [10:0] e_deny(input logic [2:0] fc);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, fc, {1'b0, fc});
   endfunction
   function automatic logic [10:0] e_grant();
      return mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd9);
   endfunction
   function automatic logic [10:0] e_lock(input logic [2:0] fc);
      return mk(1'b0, 1'b0, 1'b0, 1'b1, fc, 4'd8);
   endfunction

   // Drive n cycles with fixed inputs; outputs of each cycle are expected to be e.
   task automatic run(input int n, input logic k, input logic ok, input logic er,
                      input logic rs, input logic [10:0] e, input string nm);
      for (int i = 0; i < n; i++) begin
         key_pulse = k;
         seq_ok    = ok;
         seq_err   = er;
         reset     = rs;
         exp_q.push_back(e);
         name_q.push_back(nm);
         @(posedge clk);
         #1;
      end
      key_pulse = 1'b0;
      seq_ok    = 1'b0;
      seq_err   = 1'b0;
   endtask

   // One attempt ending in seq_err, starting in ARMED with fail count f.
   task automatic attempt_err(input logic [2:0] f);
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(f), "err_key");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(f), "err_entry");
      run(1, 1'b0, 1'b0, 1'b1, 1'b1, e_arm(f), "err_raise");
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_deny(f + 3'd1), "err_deny");
      if (f + 3'd1 < 3'd3) begin
         run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(f + 3'd1), "err_clear");
         run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(f + 3'd1), "err_armed");
      end
   endtask

   initial begin : monitor
      logic [10:0] e, got;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {fsm_clr, btn_en, unlocked, locked, fail_cnt, status_digit};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL %s @%0t: got clr=%b en=%b unl=%b lck=%b fc=%0d dig=%0d, want clr=%b en=%b unl=%b lck=%b fc=%0d dig=%0d",
                        nm, $time, got[10], got[9], got[8], got[7], got[6:4], got[3:0],
                        e[10], e[9], e[8], e[7], e[6:4], e[3:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      @(posedge clk);
      #1;
      // correct code
      run(3, 1'b0, 1'b0, 1'b0, 1'b0, e_clr(3'd0), "in_reset");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd0), "clr_after_release");
      run(2, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "armed_idle");
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "armed_key");
      run(4, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "entry_idle");
      run(1, 1'b0, 1'b1, 1'b0, 1'b1, e_arm(3'd0), "entry_ok");
      run(3, 1'b0, 1'b0, 1'b0, 1'b1, e_grant(), "grant");
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_grant(), "grant_key_ignored");
      run(6, 1'b0, 1'b0, 1'b0, 1'b1, e_grant(), "grant_tail");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd0), "grant_to_clear");
      run(2, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "grant_to_armed");
      n_cmp++;
      if (btn_en !== 1'b1 || unlocked !== 1'b0 || fail_cnt !== 3'd0) begin
         n_bad++;
         $display("FAIL direct_after_grant: en=%b unl=%b fc=%0d", btn_en, unlocked, fail_cnt);
      end

      // three failures then lockout
      attempt_err(3'd0);
      attempt_err(3'd1);
      attempt_err(3'd2);
      run(20, 1'b0, 1'b0, 1'b0, 1'b1, e_lock(3'd3), "lockout");
      run(1, 1'b1, 1'b0, 1'b1, 1'b1, e_lock(3'd3), "lockout_input_ignored");
      run(29, 1'b0, 1'b0, 1'b0, 1'b1, e_lock(3'd3), "lockout_tail");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd0), "lockout_to_clear");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "lockout_to_armed");
      n_cmp++;
      if (locked !== 1'b0 || btn_en !== 1'b1 || fail_cnt !== 3'd0 || status_digit !== 4'd0) begin
         n_bad++;
         $display("FAIL direct_after_lockout: lck=%b en=%b fc=%0d dig=%0d",
                  locked, btn_en, fail_cnt, status_digit);
      end

      // plain timeout
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "to_key");
      run(20, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "to_wait");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_deny(3'd1), "to_deny");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd1), "to_clear");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "to_armed");
      n_cmp++;
      if (fail_cnt !== 3'd1 || btn_en !== 1'b1) begin
         n_bad++;
         $display("FAIL direct_after_timeout: fc=%0d en=%b", fail_cnt, btn_en);
      end

      // key at timer==0 reloads; later seq_ok at timer==0 beats the timeout
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "rl_key");
      run(19, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "rl_wait");
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "rl_key_at_zero");
      run(19, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "rl_reloaded");
      run(1, 1'b0, 1'b1, 1'b0, 1'b1, e_arm(3'd1), "rl_ok_at_zero");
      run(10, 1'b0, 1'b0, 1'b0, 1'b1, e_grant(), "rl_grant");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd0), "rl_clear");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "rl_armed");

      // seq_ok and seq_err together
      run(1, 1'b1, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "both_key");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "both_entry");
      run(1, 1'b1, 1'b1, 1'b1, 1'b1, e_arm(3'd0), "both_raise");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_deny(3'd1), "both_deny");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd1), "both_clear");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd1), "both_armed");

      // reset in the middle of lockout
      attempt_err(3'd1);
      attempt_err(3'd2);
      run(20, 1'b0, 1'b0, 1'b0, 1'b1, e_lock(3'd3), "rst_lockout");
      run(1, 1'b0, 1'b0, 1'b0, 1'b0, e_lock(3'd3), "rst_assert");
      run(2, 1'b0, 1'b0, 1'b0, 1'b0, e_clr(3'd0), "rst_held");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_clr(3'd0), "rst_release");
      run(1, 1'b0, 1'b0, 1'b0, 1'b1, e_arm(3'd0), "rst_armed");
      n_cmp++;
      if (locked !== 1'b0 || fail_cnt !== 3'd0 || fsm_clr !== 1'b0) begin
         n_bad++;
         $display("FAIL direct_after_reset: lck=%b fc=%0d clr=%b", locked, fail_cnt, fsm_clr);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      if (n_bad != 0 || n_cmp < 12)
         $display("TEST FAILED");
      else
         $display("TEST PASSED");
      $finish;
   end

endmodule
